ahbl_sram_responder: RTL and testbench

AHB-Lite slave scratchpad SRAM with byte/halfword/word write strobes, a parameterised number of wait states, and a two-cycle ERROR response for illegal transfers. It is the responder at the far end of the DMA controller's AHB-Lite master port: the DMAC's source and destination buffers live here. It also gives the verification bench a controllable target for exercising HREADY back-pressure.

---
 rtl/ahbl_sram_responder.sv | 167 ++++++++++++++++
 tb/tb_ahbl_sram_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite scratchpad SRAM responder: byte/halfword/word writes, WS data-phase
// wait states, two-cycle ERROR response for misaligned or oversized transfers.
module ahbl_sram_responder #(
    parameter int AW = 10,
    parameter int WS = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] WS_L = 3'(WS);

    logic [31:0]   mem [2**AW];

    state_t        state_q, state_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;

    logic          accept;
    logic          legal;
    logic          commit;
    logic          rd_start;
    logic [AW-1:0] haddr_word;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_word;
    logic [31:0]   merged;
    logic [3:0]    strb;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign haddr_word = HADDR[AW+1:2];
    assign legal      = (HSIZE == 3'd0)
                      | ((HSIZE == 3'd1) & ~HADDR[0])
                      | ((HSIZE == 3'd2) & (HADDR[1:0] == 2'b00));
    assign commit     = (state_q == S_LAST) & write_q;

    always_comb begin
        case (size_q)
            2'd0:    strb = 4'b0001 << lane_q;
            2'd1:    strb = lane_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        size_d     = size_q;
        write_d    = write_q;
        rd_start   = 1'b0;
        rd_addr    = addr_q;
        case (state_q)
            S_IDLE, S_LAST, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = haddr_word;
                    lane_d  = HADDR[1:0];
                    size_d  = HSIZE[1:0];
                    write_d = HWRITE;
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (WS_L == 3'd0) begin
                        state_d  = S_LAST;
                        rd_start = ~HWRITE;
                        rd_addr  = haddr_word;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 3'd1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WS_L) begin
                    state_d    = S_LAST;
                    wait_cnt_d = 3'd0;
                    rd_start   = ~write_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // A zero-wait read landing on the word being committed this edge would
    // otherwise see the stale memory word, so strobed lanes come from HWDATA.
    assign rd_word = mem[rd_addr];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = (commit && (rd_addr == addr_q) && strb[gi])
                                     ? HWDATA[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        hrdata_d    = rd_start ? merged : hrdata_q;
        hreadyout_d = ~((state_d == S_WAIT) | (state_d == S_ERR1));
        hresp_d     = (state_d == S_ERR1) | (state_d == S_ERR2);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 3'd0;
            addr_q      <= '0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed bench: a zero-wait-state and a three-wait-state responder, each with
// HREADY looped back from its own HREADYOUT as a single-slave bus.
module tb_ahbl_sram_responder;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0;
    logic [31:0] haddr = 32'd0, hwdata = 32'd0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rdata0, rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahbl_sram_responder #(.AW(10), .WS(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy0),
        .HWDATA(hwdata), .HREADYOUT(rdy0), .HRDATA(rdata0), .HRESP(resp0)
    );

    ahbl_sram_responder #(.AW(10), .WS(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy3),
        .HWDATA(hwdata), .HREADYOUT(rdy3), .HRDATA(rdata3), .HRESP(resp3)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present an address phase (plus write data for the transfer in its data
    // phase), then advance one clock; outputs are then sampled 1 time unit later.
    task automatic phase(input logic s0, input logic s3, input logic [1:0] tr,
                         input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        hsel0  = s0;
        hsel3  = s3;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hwdata = wd;
        tick();
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout0 got %b want 1", rdy0); end
        n_checks++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp0 got %b want 0", resp0); end
        n_checks++; if (rdata0 !== 32'd0) begin n_fail++; $display("FAIL reset_hrdata0 got %h want 00000000", rdata0); end
        n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout3 got %b want 1", rdy3); end
        n_checks++; if (rdata3 !== 32'd0) begin n_fail++; $display("FAIL reset_hrdata3 got %h want 00000000", rdata3); end
        HRESETn = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_word_rw();
        phase(1, 0, T_NS, 1, 32'h010, 3'd2, 32'h0);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL word_wr_ready got %b want 1", rdy0); end
        n_checks++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL word_wr_resp got %b want 0", resp0); end
        phase(1, 0, T_NS, 0, 32'h010, 3'd2, 32'hDEADBEEF);
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_b2b got %h want deadbeef", rdata0); end
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL word_rd_ready got %b want 1", rdy0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_hold got %h want deadbeef", rdata0); end
        phase(1, 0, T_NS, 0, 32'h010, 3'd2, 32'h0);
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_mem got %h want deadbeef", rdata0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        $display("word_rw: write 0x010 = deadbeef, read back %h", rdata0);
    endtask

    task automatic test_busy();
        phase(1, 0, T_BUSY, 1, 32'h010, 3'd2, 32'h0);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL busy_ready got %b want 1", rdy0); end
        n_checks++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL busy_resp got %b want 0", resp0); end
        phase(1, 0, T_NS, 0, 32'h010, 3'd2, 32'hFFFFFFFF);
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL busy_no_write got %h want deadbeef", rdata0); end
        $display("busy: BUSY write ignored, 0x010 reads %h", rdata0);
    endtask

    task automatic test_strobes();
        phase(1, 0, T_NS, 1, 32'h020, 3'd2, 32'h0);
        phase(1, 0, T_NS, 1, 32'h022, 3'd0, 32'h00000000);
        phase(1, 0, T_NS, 1, 32'h020, 3'd1, 32'h00AA0000);
        phase(1, 0, T_NS, 0, 32'h020, 3'd2, 32'h00001234);
        n_checks++; if (rdata0 !== 32'h00AA1234) begin n_fail++; $display("FAIL strobe_merge got %h want 00aa1234", rdata0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        phase(1, 0, T_NS, 0, 32'h020, 3'd2, 32'h0);
        n_checks++; if (rdata0 !== 32'h00AA1234) begin n_fail++; $display("FAIL strobe_mem got %h want 00aa1234", rdata0); end
        phase(1, 0, T_NS, 1, 32'h023, 3'd0, 32'h0);
        phase(1, 0, T_NS, 0, 32'h020, 3'd2, 32'h5B000000);
        n_checks++; if (rdata0 !== 32'h5BAA1234) begin n_fail++; $display("FAIL strobe_lane3 got %h want 5baa1234", rdata0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        $display("strobes: 0x020 reads %h", rdata0);
    endtask

    task automatic test_forwarding();
        phase(1, 0, T_NS, 1, 32'h040, 3'd2, 32'h0);
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'hCAFEF00D);
        phase(1, 0, T_NS, 1, 32'h040, 3'd2, 32'h0);
        phase(1, 0, T_NS, 0, 32'h040, 3'd2, 32'h11223344);
        n_checks++; if (rdata0 !== 32'h11223344) begin n_fail++; $display("FAIL fwd_read got %h want 11223344", rdata0); end
        n_checks++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL fwd_resp got %b want 0", resp0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        $display("forwarding: 0x040 reads %h", rdata0);
    endtask

    task automatic test_errors();
        phase(1, 0, T_NS, 1, 32'h042, 3'd2, 32'h0);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL err1_ready got %b want 0", rdy0); end
        n_checks++; if (resp0 !== 1'b1) begin n_fail++; $display("FAIL err1_resp got %b want 1", resp0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'hFFFFFFFF);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL err2_ready got %b want 1", rdy0); end
        n_checks++; if (resp0 !== 1'b1) begin n_fail++; $display("FAIL err2_resp got %b want 1", resp0); end
        phase(1, 0, T_NS, 1, 32'h040, 3'd3, 32'hFFFFFFFF);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL size3_err1_ready got %b want 0", rdy0); end
        n_checks++; if (resp0 !== 1'b1) begin n_fail++; $display("FAIL size3_err1_resp got %b want 1", resp0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'hFFFFFFFF);
        n_checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin n_fail++; $display("FAIL size3_err2 got ready=%b resp=%b want 1 1", rdy0, resp0); end
        phase(1, 0, T_NS, 0, 32'h040, 3'd2, 32'hFFFFFFFF);
        n_checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin n_fail++; $display("FAIL after_err_okay got ready=%b resp=%b want 1 0", rdy0, resp0); end
        n_checks++; if (rdata0 !== 32'h11223344) begin n_fail++; $display("FAIL after_err_data got %h want 11223344", rdata0); end
        phase(1, 0, T_NS, 0, 32'h041, 3'd1, 32'h0);
        n_checks++; if (rdy0 !== 1'b0 || resp0 !== 1'b1) begin n_fail++; $display("FAIL half_odd_err1 got ready=%b resp=%b want 0 1", rdy0, resp0); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin n_fail++; $display("FAIL err_to_idle got ready=%b resp=%b want 1 0", rdy0, resp0); end
        $display("errors: illegal transfers answered with ERROR, 0x040 still %h", rdata0);
    endtask

    task automatic test_wait_states();
        phase(0, 1, T_NS, 1, 32'h100, 3'd2, 32'h0);
        n_checks++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ws_wr_wait1 got %b want 0", rdy3); end
        for (int k = 2; k <= 3; k++) begin
            phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h55AA55AA);
            n_checks++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ws_wr_wait%0d got %b want 0", k, rdy3); end
        end
        phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h55AA55AA);
        n_checks++; if (rdy3 !== 1'b1 || resp3 !== 1'b0) begin n_fail++; $display("FAIL ws_wr_last got ready=%b resp=%b want 1 0", rdy3, resp3); end
        n_checks++; if (rdata3 !== 32'd0) begin n_fail++; $display("FAIL ws_wr_rdata got %h want 00000000", rdata3); end
        phase(0, 1, T_NS, 0, 32'h100, 3'd2, 32'h55AA55AA);
        for (int k = 1; k <= 3; k++) begin
            n_checks++; if (rdy3 !== 1'b0 || rdata3 !== 32'd0) begin n_fail++; $display("FAIL ws_rd_wait%0d got ready=%b data=%h want 0 00000000", k, rdy3, rdata3); end
            phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        end
        n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL ws_rd_last got %b want 1", rdy3); end
        n_checks++; if (rdata3 !== 32'h55AA55AA) begin n_fail++; $display("FAIL ws_rd_data got %h want 55aa55aa", rdata3); end
        phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (rdy3 !== 1'b1 || rdata3 !== 32'h55AA55AA) begin n_fail++; $display("FAIL ws_rd_hold got ready=%b data=%h want 1 55aa55aa", rdy3, rdata3); end
        $display("wait_states: WS=3 read of 0x100 returned %h", rdata3);
    endtask

    task automatic test_reset_mid();
        phase(0, 1, T_NS, 1, 32'h100, 3'd2, 32'h0);
        phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h77777777);
        #2 HRESETn = 1'b0;
        #1;
        n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", rdy3); end
        n_checks++; if (resp3 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp got %b want 0", resp3); end
        n_checks++; if (rdata3 !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want 00000000", rdata3); end
        #1 HRESETn = 1'b1;
        tick();
        phase(0, 1, T_NS, 0, 32'h100, 3'd2, 32'h0);
        for (int k = 0; k < 3; k++) phase(0, 1, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (rdy3 !== 1'b1 || rdata3 !== 32'h55AA55AA) begin n_fail++; $display("FAIL rst_mid_mem got ready=%b data=%h want 1 55aa55aa", rdy3, rdata3); end
        phase(0, 0, T_IDLE, 0, 32'h0, 3'd0, 32'h0);
        $display("reset_mid: dropped write, 0x100 reads %h", rdata3);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_busy();
        test_strobes();
        test_forwarding();
        test_errors();
        test_wait_states();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
